// File: rtl/gpio_cfg_pkg.sv
// Shared constants for the GPIO configuration serial chain: word width,
// decoded bit offsets and the two reset configurations used along the chain.
package gpio_cfg_pkg;

  localparam int IO_CTRL_BITS = 13;

  // Bit positions of the decoded controls inside a pad configuration word
  localparam int OEB     = 1;
  localparam int INP_DIS = 3;

  // Reset configurations: bidirectional pads vs. input-only pads
  localparam logic [IO_CTRL_BITS-1:0] CFG_BIDIR = 13'h1803;
  localparam logic [IO_CTRL_BITS-1:0] CFG_INPUT = 13'h0403;

  // Reset configuration for pad idx in a chain of n pads: the two pads at
  // each end of the chain are bidirectional, everything else is input-only.
  function automatic logic [IO_CTRL_BITS-1:0] pad_reset_cfg(input int idx, input int n);
    if (idx == 0 || idx == 1 || idx == n - 2 || idx == n - 1) begin
      return CFG_BIDIR;
    end
    return CFG_INPUT;
  endfunction

endpackage

// File: rtl/gpio_cfg_deserializer.sv
// Per-pad receiver for the GPIO configuration serial chain. Edge-detects the
// loader's serial clock and strobe in the wb_clk_i domain, shifts data MSB
// first, retimes clock/strobe/data to the next pad, and latches a complete
// configuration word on an aligned load strobe.
//
// Serial protocol (all levels sampled on wb_clk_i):
//   rise        : serial_clock_in 0->1, shifts serial_data_in into shreg.
//   load        : serial_resetn_in 1->0 while serial_clock_in=1; latches
//                 shreg only if a whole number of words has been shifted.
//   chain reset : serial_resetn_in=0 while serial_clock_in=0; clears the
//                 partial shift state, keeps the latched configuration.
// A rise and a load in the same cycle shift first, then evaluate the load.
module gpio_cfg_deserializer #(
  parameter int                      IO_CTRL_BITS = gpio_cfg_pkg::IO_CTRL_BITS,
  parameter logic [IO_CTRL_BITS-1:0] RESET_CFG    = gpio_cfg_pkg::CFG_INPUT
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    serial_clock_in,
  input  logic                    serial_resetn_in,
  input  logic                    serial_data_in,
  output logic                    serial_clock_out,
  output logic                    serial_resetn_out,
  output logic                    serial_data_out,
  output logic [IO_CTRL_BITS-1:0] pad_cfg,
  output logic                    pad_oeb,
  output logic                    pad_inp_dis,
  output logic                    cfg_valid,
  output logic                    cfg_update,
  output logic                    load_err
);

  import gpio_cfg_pkg::*;

  localparam int             MSB      = IO_CTRL_BITS - 1;
  localparam logic [3:0]     LAST_BIT = 4'(IO_CTRL_BITS - 1);

  logic                    clk_q;
  logic                    rstn_q;
  logic [IO_CTRL_BITS-1:0] shreg;
  logic [3:0]              bit_cnt;

  logic                    rise;
  logic                    load;
  logic                    chain_rst;
  logic [IO_CTRL_BITS-1:0] shreg_nxt;
  logic [3:0]              cnt_nxt;

  // Events are qualified against the previous-cycle copies, so held levels
  // (slow bit-banged inputs) never re-trigger.
  assign rise      = serial_clock_in & ~clk_q;
  assign load      = ~serial_resetn_in & rstn_q & serial_clock_in;
  assign chain_rst = ~serial_resetn_in & ~serial_clock_in;

  // Post-event shift state; the load decision looks at these values so a
  // rise coinciding with the load is already included.
  always_comb begin
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    if (chain_rst) begin
      shreg_nxt = '0;
      cnt_nxt   = '0;
    end else if (rise) begin
      shreg_nxt = {shreg[MSB-1:0], serial_data_in};
      cnt_nxt   = (bit_cnt == LAST_BIT) ? 4'd0 : bit_cnt + 4'd1;
    end
  end

  // Edge-detect history, shift register and bit counter
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      clk_q   <= 1'b0;
      rstn_q  <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      clk_q   <= serial_clock_in;
      rstn_q  <= serial_resetn_in;
      shreg   <= shreg_nxt;
      bit_cnt <= cnt_nxt;
    end
  end

  // One-cycle retiming towards the next pad; data carries the pre-shift MSB
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      serial_clock_out  <= 1'b0;
      serial_resetn_out <= 1'b0;
      serial_data_out   <= 1'b0;
    end else begin
      serial_clock_out  <= serial_clock_in;
      serial_resetn_out <= serial_resetn_in;
      serial_data_out   <= shreg[MSB];
    end
  end

  // Configuration latch with clean-load / misaligned-load pulses
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pad_cfg    <= RESET_CFG;
      cfg_valid  <= 1'b0;
      cfg_update <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      load_err   <= 1'b0;
      if (load) begin
        if (cnt_nxt == 4'd0) begin
          pad_cfg    <= shreg_nxt;
          cfg_update <= 1'b1;
          cfg_valid  <= 1'b1;
        end else begin
          load_err   <= 1'b1;
        end
      end
    end
  end

  assign pad_oeb     = pad_cfg[OEB];
  assign pad_inp_dis = pad_cfg[INP_DIS];

endmodule
